// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 32-bit ALU: accepts decoded instructions on a
// valid/ready request port, drives registered operands/opcode, returns results on a response port.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_ALUop,
    input  logic [2:0]        req_funct3,
    input  logic              req_funct7b5,
    input  logic [DATA_W-1:0] req_rs1,
    input  logic [DATA_W-1:0] req_rs2,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [3:0]        ALU_control,
    input  logic [DATA_W-1:0] Aout,
    input  logic              zeroFlag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_branch_taken,
    output logic              res_illegal,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       illegal_q;
    logic       branch_q;
    logic       accept;
    logic       handshake;

    always_comb begin
        dec_code    = 4'b0010;
        dec_illegal = 1'b0;
        case (req_ALUop)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b10: begin
                case (req_funct3)
                    3'b000:  dec_code = req_funct7b5 ? 4'b0110 : 4'b0010;
                    3'b111:  dec_code = 4'b0000;
                    3'b110:  dec_code = 4'b0001;
                    default: begin
                        dec_code    = 4'b1111;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_code    = 4'b1111;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is masked by rst_n so nothing looks acceptable while reset is held.
    assign req_ready = rst_n && (state == IDLE);
    assign res_valid = (state == RESP);
    assign accept    = (state == IDLE) && req_valid;
    assign handshake = (state == RESP) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1          <= '0;
            a2          <= '0;
            ALU_control <= 4'b0000;
            illegal_q   <= 1'b0;
            branch_q    <= 1'b0;
        end else if (accept) begin
            a1          <= req_rs1;
            a2          <= req_rs2;
            ALU_control <= dec_code;
            illegal_q   <= dec_illegal;
            branch_q    <= (req_ALUop == 2'b01);
        end
    end

    // The ALU output is sampled at the end of the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data         <= '0;
            res_zero         <= 1'b0;
            res_branch_taken <= 1'b0;
            res_illegal      <= 1'b0;
        end else if (state == EXEC) begin
            res_data         <= Aout;
            res_zero         <= zeroFlag;
            res_branch_taken <= zeroFlag & branch_q;
            res_illegal      <= illegal_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (handshake) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table vectors, randomized ops against a
// behavioural model, backpressure, counter wrap and mid-operation reset.
module tb_alu_issue_ctrl;

    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_ALUop = 2'b00;
    logic [2:0]        req_funct3 = 3'b000;
    logic              req_funct7b5 = 1'b0;
    logic [31:0]       req_rs1 = 32'd0;
    logic [31:0]       req_rs2 = 32'd0;
    logic [31:0]       a1;
    logic [31:0]       a2;
    logic [3:0]        ALU_control;
    logic [31:0]       Aout;
    logic              zeroFlag;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [31:0]       res_data;
    logic              res_zero;
    logic              res_branch_taken;
    logic              res_illegal;
    logic [CNT_W-1:0]  op_count;

    int vec_count   = 0;
    int miscompares = 0;
    int exp_count   = 0;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        b5;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  code;
        logic        illegal;
        logic [31:0] data;
        logic        zero;
        logic        branch;
        int          stall;
    } vec_t;

    vec_t vecs[10];

    alu_issue_ctrl #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ALUop(req_ALUop), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .a1(a1), .a2(a2), .ALU_control(ALU_control),
        .Aout(Aout), .zeroFlag(zeroFlag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero),
        .res_branch_taken(res_branch_taken), .res_illegal(res_illegal),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Environment ALU: unknown codes return 0.
    always_comb begin
        case (ALU_control)
            4'b0010: Aout = a1 + a2;
            4'b0110: Aout = a1 - a2;
            4'b0000: Aout = a1 & a2;
            4'b0001: Aout = a1 | a2;
            default: Aout = 32'd0;
        endcase
        zeroFlag = (Aout == 32'd0);
    end

    function automatic vec_t model(input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic b5, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input int stall);
        vec_t v;
        int kind;
        logic [3:0] code_tab[5];
        code_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111};
        if (aluop == 2'b00)      kind = 0;
        else if (aluop == 2'b01) kind = 1;
        else if (aluop == 2'b11) kind = 4;
        else if (f3 == 3'd0)     kind = b5 ? 1 : 0;
        else if (f3 == 3'd7)     kind = 2;
        else if (f3 == 3'd6)     kind = 3;
        else                     kind = 4;
        v.aluop = aluop; v.f3 = f3; v.b5 = b5; v.rs1 = rs1; v.rs2 = rs2; v.stall = stall;
        v.code    = code_tab[kind];
        v.illegal = (kind == 4);
        case (kind)
            0:       v.data = rs1 + rs2;
            1:       v.data = rs1 - rs2;
            2:       v.data = rs1 & rs2;
            3:       v.data = rs1 | rs2;
            default: v.data = 32'd0;
        endcase
        v.zero   = (v.data == 32'd0);
        v.branch = v.zero && (aluop == 2'b01);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveJunk();
        req_valid    = 1'b1;
        req_ALUop    = 2'($urandom_range(0, 3));
        req_funct3   = 3'($urandom_range(0, 7));
        req_funct7b5 = 1'($urandom_range(0, 1));
        req_rs1      = $urandom;
        req_rs2      = $urandom;
    endtask

    // Runs one full transaction starting from IDLE at a negedge.
    task automatic applyStimulus(input vec_t v);
        logic [CNT_W-1:0] cnt_exp;
        cnt_exp = CNT_W'(exp_count % (1 << CNT_W));
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_ALUop    = v.aluop;
        req_funct3   = v.f3;
        req_funct7b5 = v.b5;
        req_rs1      = v.rs1;
        req_rs2      = v.rs2;
        @(negedge clk);
        driveJunk();
        res_ready = 1'($urandom_range(0, 1));
        checkOutput("res_valid_exec", 32'(res_valid), 32'd0);
        checkOutput("req_ready_exec", 32'(req_ready), 32'd0);
        checkOutput("alu_control", 32'(ALU_control), 32'(v.code));
        checkOutput("a1", a1, v.rs1);
        checkOutput("a2", a2, v.rs2);
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("res_valid_resp", 32'(res_valid), 32'd1);
        checkOutput("res_data", res_data, v.data);
        checkOutput("res_zero", 32'(res_zero), 32'(v.zero));
        checkOutput("res_branch", 32'(res_branch_taken), 32'(v.branch));
        checkOutput("res_illegal", 32'(res_illegal), 32'(v.illegal));
        checkOutput("req_ready_resp", 32'(req_ready), 32'd0);
        for (int s = 0; s < v.stall; s++) begin
            driveJunk();
            @(negedge clk);
            checkOutput("stall_valid", 32'(res_valid), 32'd1);
            checkOutput("stall_data", res_data, v.data);
            checkOutput("stall_flags", {29'd0, res_zero, res_branch_taken, res_illegal},
                        {29'd0, v.zero, v.branch, v.illegal});
            checkOutput("stall_ready", 32'(req_ready), 32'd0);
            checkOutput("stall_count", 32'(op_count), 32'(cnt_exp));
            checkOutput("stall_a1", a1, v.rs1);
            checkOutput("stall_code", 32'(ALU_control), 32'(v.code));
        end
        res_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        exp_count++;
        res_ready = 1'b0;
        checkOutput("res_valid_done", 32'(res_valid), 32'd0);
        checkOutput("op_count", 32'(op_count), 32'(exp_count % (1 << CNT_W)));
        checkOutput("req_ready_done", 32'(req_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{2'b10, 3'b000, 1'b0, 32'd5,        32'd7,        4'b0010, 1'b0, 32'd12,       1'b0, 1'b0, 0};
        vecs[1] = '{2'b01, 3'b000, 1'b0, 32'h1234,     32'h1234,     4'b0110, 1'b0, 32'd0,        1'b1, 1'b1, 0};
        vecs[2] = '{2'b01, 3'b000, 1'b0, 32'h1234,     32'h1235,     4'b0110, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vecs[3] = '{2'b10, 3'b111, 1'b0, 32'hF0F0,     32'h0FF0,     4'b0000, 1'b0, 32'h00F0,     1'b0, 1'b0, 5};
        vecs[4] = '{2'b10, 3'b110, 1'b0, 32'hF000,     32'h000F,     4'b0001, 1'b0, 32'hF00F,     1'b0, 1'b0, 0};
        vecs[5] = '{2'b10, 3'b010, 1'b0, 32'h55,       32'h22,       4'b1111, 1'b1, 32'd0,        1'b1, 1'b0, 2};
        vecs[6] = '{2'b10, 3'b000, 1'b1, 32'd3,        32'd5,        4'b0110, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 0};
        vecs[7] = '{2'b00, 3'b101, 1'b1, 32'hFFFFFFFF, 32'd1,        4'b0010, 1'b0, 32'd0,        1'b1, 1'b0, 0};
        vecs[8] = '{2'b11, 3'b000, 1'b0, 32'd1,        32'd2,        4'b1111, 1'b1, 32'd0,        1'b1, 1'b0, 0};
        vecs[9] = '{2'b01, 3'b101, 1'b1, 32'd10,       32'd10,       4'b0110, 1'b0, 32'd0,        1'b1, 1'b1, 3};

        // Reset held with a request pending.
        req_valid = 1'b1;
        req_ALUop = 2'b10;
        req_rs1   = 32'hDEAD;
        req_rs2   = 32'hBEEF;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_a1", a1, 32'd0);
        checkOutput("rst_a2", a2, 32'd0);
        checkOutput("rst_code", 32'(ALU_control), 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
        checkOutput("rst_flags", {29'd0, res_zero, res_branch_taken, res_illegal}, 32'd0);
        checkOutput("rst_op_count", 32'(op_count), 32'd0);
        req_valid = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
        checkOutput("post_rst_valid", 32'(res_valid), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] r1;
            logic [31:0] r2;
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            applyStimulus(model(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                                1'($urandom_range(0, 1)), r1, r2, $urandom_range(0, 3)));
        end

        // Reset asserted while the operation is in EXEC.
        checkOutput("t6_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_ALUop = 2'b00;
        req_rs1   = 32'd9;
        req_rs2   = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        res_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        checkOutput("t6_valid", 32'(res_valid), 32'd0);
        checkOutput("t6_count", 32'(op_count), 32'd0);
        checkOutput("t6_code", 32'(ALU_control), 32'd0);
        checkOutput("t6_a1", a1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t6_valid_hold", 32'(res_valid), 32'd0);
        end
        res_ready = 1'b0;
        rst_n     = 1'b1;
        exp_count = 0;
        @(negedge clk);
        checkOutput("t6_ready_after", 32'(req_ready), 32'd1);
        checkOutput("t6_valid_after", 32'(res_valid), 32'd0);
        checkOutput("t6_count_after", 32'(op_count), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(model(2'b10, 3'b000, 1'b0, 32'(i), 32'd1, 0));
        end
        checkOutput("wrap_count", 32'(op_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
